// File: rtl/alu_sequencer.sv
// alu_sequencer
// Runs one complete ALU operation for each request from the microcode control
// unit. It strobes the B-operand latch, holds the unit-select code for the
// required settle time, repeats roll steps, strobes the flag latch and reports
// busy/done. Every output is registered.
//
// Ports:
//   clk4       clock, all state changes on the rising edge
//   nreset     asynchronous active-low reset
//   nstart     active-low request, sampled only in IDLE
//   nabort     active-low synchronous abort (ignored in IDLE apart from
//              dropping a simultaneous request)
//   op[3:0]    requested unit: 8 ADD, 9 AND, 10 OR, 11 XOR, 12 ROLL,
//              13 NOT, 14 CS1, 15 CS2 (op<8 is illegal)
//   rmode[2:0] roll mode for ROLL
//   count[3:0] roll repeat count, 0 means 16
//   runit[3:0] unit code to the alu, 0 = idle
//   irroll[2:0] roll mode to the alu
//   nwalu      active-low B-operand latch strobe
//   nflstrobe  active-low flag-latch strobe
//   nbusy      active-low, low from the cycle after acceptance through DONE
//   ndone      active-low one-cycle completion pulse
//   nerr       active-low one-cycle pulse for an illegal request
//   dbg_state  current FSM state (IDLE=0 LOADB=1 EXEC=2 GAP=3 FLAG=4 DONE=5)
//
// Request protocol: a request is a single cycle with nstart=0 while the
// sequencer is IDLE and nabort=1. op/rmode/count are captured on that edge and
// held for the whole operation; nstart seen in any other state is dropped, so
// the requester must wait for nbusy to return high before asking again.

module alu_sequencer #(
    parameter int unsigned ADD_CYCLES   = 2,
    parameter int unsigned LOGIC_CYCLES = 1
) (
    input  logic       clk4,
    input  logic       nreset,
    input  logic       nstart,
    input  logic       nabort,
    input  logic [3:0] op,
    input  logic [2:0] rmode,
    input  logic [3:0] count,
    output logic [3:0] runit,
    output logic [2:0] irroll,
    output logic       nwalu,
    output logic       nflstrobe,
    output logic       nbusy,
    output logic       ndone,
    output logic       nerr,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADB = 3'd1,
        S_EXEC  = 3'd2,
        S_GAP   = 3'd3,
        S_FLAG  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_ROLL = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;

    // Last value of the step counter in a non-ROLL EXEC phase.
    localparam logic [4:0] ADD_LAST   = 5'(ADD_CYCLES - 1);
    localparam logic [4:0] LOGIC_LAST = 5'(LOGIC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [4:0] step_q, step_d;      // 5 bits so a 16-step roll never wraps
    logic [3:0] op_q, op_d;
    logic [2:0] rmode_q, rmode_d;
    logic [3:0] count_q, count_d;
    logic       err_d;

    logic [4:0] roll_steps;
    logic       is_roll_q;

    logic [3:0] runit_d;
    logic [2:0] irroll_d;
    logic       nwalu_d, nflstrobe_d, nbusy_d, ndone_d, nerr_d;

    assign roll_steps = (count_q == 4'd0) ? 5'd16 : {1'b0, count_q};
    assign is_roll_q  = (op_q == OP_ROLL);
    assign dbg_state  = state_q;

    // State, latched operands and registered outputs.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            step_q    <= 5'd0;
            op_q      <= 4'd0;
            rmode_q   <= 3'd0;
            count_q   <= 4'd0;
            runit     <= 4'd0;
            irroll    <= 3'd0;
            nwalu     <= 1'b1;
            nflstrobe <= 1'b1;
            nbusy     <= 1'b1;
            ndone     <= 1'b1;
            nerr      <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            op_q      <= op_d;
            rmode_q   <= rmode_d;
            count_q   <= count_d;
            runit     <= runit_d;
            irroll    <= irroll_d;
            nwalu     <= nwalu_d;
            nflstrobe <= nflstrobe_d;
            nbusy     <= nbusy_d;
            ndone     <= ndone_d;
            nerr      <= nerr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        rmode_d = rmode_q;
        count_d = count_q;
        err_d   = 1'b0;

        if (state_q != S_IDLE && !nabort) begin
            state_d = S_IDLE;
            step_d  = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!nstart && nabort) begin
                        if (op[3]) begin
                            op_d    = op;
                            rmode_d = rmode;
                            count_d = count;
                            step_d  = 5'd0;
                            // NOT and ROLL have no B operand to latch.
                            if (op == OP_ROLL || op == OP_NOT)
                                state_d = S_EXEC;
                            else
                                state_d = S_LOADB;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOADB: begin
                    state_d = S_EXEC;
                    step_d  = 5'd0;
                end
                S_EXEC: begin
                    if (is_roll_q) begin
                        // step_q counts roll steps already completed.
                        if (step_q + 5'd1 == roll_steps) begin
                            state_d = S_FLAG;
                            step_d  = 5'd0;
                        end else begin
                            state_d = S_GAP;
                            step_d  = step_q + 5'd1;
                        end
                    end else if (op_q == OP_ADD) begin
                        if (step_q == ADD_LAST) begin
                            state_d = S_FLAG;
                            step_d  = 5'd0;
                        end else begin
                            step_d = step_q + 5'd1;
                        end
                    end else begin
                        if (step_q == LOGIC_LAST) begin
                            state_d = S_DONE;
                            step_d  = 5'd0;
                        end else begin
                            step_d = step_q + 5'd1;
                        end
                    end
                end
                S_GAP:   state_d = S_EXEC;
                S_FLAG:  state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    step_d  = 5'd0;
                end
            endcase
        end
    end

    // Output logic: values for the coming cycle, decoded from the next state
    // so that the registered outputs line up with the state they describe.
    always_comb begin
        runit_d     = 4'd0;
        irroll_d    = 3'd0;
        nwalu_d     = 1'b1;
        nflstrobe_d = 1'b1;
        nbusy_d     = (state_d == S_IDLE);
        ndone_d     = 1'b1;
        nerr_d      = !err_d;

        case (state_d)
            S_LOADB: nwalu_d = 1'b0;
            S_EXEC: begin
                runit_d = op_d;
                if (op_d == OP_ROLL) irroll_d = rmode_d;
            end
            S_GAP: irroll_d = rmode_d;
            S_FLAG: begin
                nflstrobe_d = 1'b0;
                // Roll mode stays on the bus until DONE clears it.
                if (op_d == OP_ROLL) irroll_d = rmode_d;
            end
            S_DONE:  ndone_d = 1'b0;
            default: ;
        endcase
    end

endmodule
